// File: rtl/frag_mem_ctrl.sv
// rtl/frag_mem_ctrl.sv - fragment SRAM sequencer sharing one byte-write loader and NREQ fragment readers
module frag_mem_ctrl #(
  parameter int AW       = 16,
  parameter int BYTE     = 8,
  parameter int ODW      = 256,
  parameter int NREQ     = 2,
  parameter int WR_BURST = 4,
  parameter int TO_CYC   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [BYTE-1:0]      wr_data,
  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*AW-1:0]   rd_addr,
  output logic [NREQ-1:0]      rd_gnt,
  output logic [NREQ-1:0]      rd_valid,
  output logic                 rd_err,
  output logic [BYTE*ODW-1:0]  rd_data,
  output logic                 mem_WnR,
  output logic                 mem_req,
  output logic [AW-1:0]        mem_addr,
  output logic [BYTE-1:0]      mem_data,
  input  logic                 mem_ready,
  input  logic [BYTE*ODW-1:0]  mem_rdata,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(WR_BURST + 1);
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [IW-1:0]        r_rr_ptr;
  logic [IW-1:0]        r_id;
  logic [SW-1:0]        r_wr_streak;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_mem_wnr;
  logic                 r_mem_req;
  logic [AW-1:0]        r_mem_addr;
  logic [BYTE-1:0]      r_mem_data;
  logic [NREQ-1:0]      r_rd_valid;
  logic                 r_rd_err;
  logic [BYTE*ODW-1:0]  r_rd_data;

  logic [NREQ-1:0]      w_rot;
  logic                 w_hit;
  logic [IW-1:0]        w_pick;
  logic [AW-1:0]        w_pick_addr;
  logic                 w_idle;
  logic                 w_rd_sel;
  logic                 w_wr_acc;
  logic                 w_to_hit;

  // Round-robin search: rotate requests so bit 0 is rr_ptr, take the lowest set bit
  always_comb begin
    w_rot  = NREQ'({rd_req, rd_req} >> r_rr_ptr);
    w_hit  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_hit && w_rot[k]) begin
        w_hit  = 1'b1;
        w_pick = IW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    w_pick_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IW'(i)) w_pick_addr = rd_addr[i*AW +: AW];
    end
  end

  // Accept decisions: a read wins when the loader is idle or has used up its burst
  always_comb begin
    w_idle   = !rst && (r_state == IDLE);
    w_rd_sel = w_idle && w_hit && (!wr_valid || (r_wr_streak == SW'(WR_BURST)));
    w_wr_acc = w_idle && !w_rd_sel && wr_valid;
    w_to_hit = (r_to_cnt == TW'(TO_CYC - 1));
    wr_ready = w_wr_acc;
    rd_gnt   = w_rd_sel ? (NREQ'(1) << w_pick) : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_rd_sel) w_next_state = RD_ISSUE;
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT:  if (mem_ready || w_to_hit) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Memory-side strobes, arbitration bookkeeping and read response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_wr_streak <= '0;
      r_to_cnt    <= '0;
      r_mem_wnr   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rd_valid  <= '0;
      r_rd_err    <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rd_valid <= '0;
      r_rd_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rd_sel) begin
            // mem_addr doubles as the latched fragment-aligned read address
            r_mem_req   <= 1'b1;
            r_mem_wnr   <= 1'b0;
            r_mem_addr  <= w_pick_addr & ~AW'(ODW - 1);
            r_id        <= w_pick;
            r_rr_ptr    <= IW'((int'(w_pick) + 1) % NREQ);
            r_wr_streak <= '0;
          end else if (w_wr_acc) begin
            r_mem_req  <= 1'b1;
            r_mem_wnr  <= 1'b1;
            r_mem_addr <= wr_addr;
            r_mem_data <= wr_data;
            if (|rd_req)
              r_wr_streak <= (r_wr_streak == SW'(WR_BURST)) ? r_wr_streak : r_wr_streak + 1'b1;
            else
              r_wr_streak <= '0;
          end else begin
            r_mem_req <= 1'b0;
          end
        end
        RD_ISSUE: begin
          r_mem_req <= 1'b0;
          r_to_cnt  <= '0;
        end
        RD_WAIT: begin
          if (mem_ready) begin
            r_rd_data  <= mem_rdata;
            r_rd_valid <= NREQ'(1) << r_id;
          end else if (w_to_hit) begin
            r_rd_valid <= NREQ'(1) << r_id;
            r_rd_err   <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign mem_WnR  = r_mem_wnr;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign rd_data  = r_rd_data;
  assign busy     = (r_state != IDLE) || r_mem_req;

endmodule

// File: tb/tb_frag_mem_ctrl.sv
// tb/tb_frag_mem_ctrl.sv - directed scoreboard bench for frag_mem_ctrl
module tb_frag_mem_ctrl;

  localparam int AW   = 16;
  localparam int NREQ = 2;
  localparam int DW   = 8 * 256;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic            err;
    logic [DW-1:0]   data;
  } rexp_t;

  logic                 clk;
  logic                 rst;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [7:0]           wr_data;
  logic [NREQ-1:0]      rd_req;
  logic [NREQ*AW-1:0]   rd_addr;
  logic [NREQ-1:0]      rd_gnt;
  logic [NREQ-1:0]      rd_valid;
  logic                 rd_err;
  logic [DW-1:0]        rd_data;
  logic                 mem_WnR;
  logic                 mem_req;
  logic [AW-1:0]        mem_addr;
  logic [7:0]           mem_data;
  logic                 mem_ready;
  logic [DW-1:0]        mem_rdata;
  logic                 busy;

  logic                 mem_auto;
  logic                 inject;
  logic                 m_ready;
  logic                 m_pend;
  logic [AW-1:0]        m_addr;

  int                   n_checks;
  int                   n_fail;
  rexp_t                rq[$];
  logic [23:0]          wq[$];
  logic [DW-1:0]        exp_last;

  frag_mem_ctrl #(
    .AW(AW), .BYTE(8), .ODW(256), .NREQ(NREQ), .WR_BURST(4), .TO_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_err(rd_err), .rd_data(rd_data),
    .mem_WnR(mem_WnR), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] pat(input logic [15:0] a);
    return {128{a ^ 16'h5A3C}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ready one cycle after a read strobe, data keyed on the strobed address
  always @(negedge clk) begin
    m_ready = m_pend;
    m_pend  = mem_req && !mem_WnR && mem_auto && !rst;
    if (mem_req && !mem_WnR) m_addr = mem_addr;
  end
  assign mem_ready = m_ready || inject;
  assign mem_rdata = m_ready ? pat(m_addr) : {128{16'hDEAD}};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [NREQ-1:0] vld, input logic err, input logic [DW-1:0] data);
    rexp_t e;
    e.vld  = vld;
    e.err  = err;
    e.data = data;
    rq.push_back(e);
    if (!err) exp_last = data;
  endtask

  task automatic monitor();
    rexp_t       e;
    logic [23:0] w;
    if (mem_req === 1'b1 && mem_WnR === 1'b1) begin
      if (wq.size() == 0) check("wr_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
      else begin
        w = wq.pop_front();
        check("wr_mem_addr", 64'(mem_addr), 64'(w[23:8]));
        check("wr_mem_data", 64'(mem_data), 64'(w[7:0]));
      end
    end
    if (wr_valid && wr_ready === 1'b1) wq.push_back({wr_addr, wr_data});
    if (rd_valid !== '0 && rd_valid !== 'x) begin
      if (rq.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'h0);
      else begin
        e = rq.pop_front();
        check("rd_valid", 64'(rd_valid), 64'(e.vld));
        check("rd_err", 64'(rd_err), 64'(e.err));
        check("rd_data_lo", rd_data[63:0], e.data[63:0]);
        check("rd_data_all", 64'(rd_data === e.data), 64'h1);
      end
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    monitor();
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    nedge();
    pedge();
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      nedge();
      if (busy === 1'b0 && wq.size() == 0 && rq.size() == 0) done = 1'b1;
      pedge();
    end
    check("wait_idle", 64'(done), 64'h1);
  endtask

  logic [NREQ-1:0] exp_seq [4];
  int nwr, gcyc, rcyc, nb4, ng, k;
  logic acc, g;

  initial begin
    n_checks = 0; n_fail = 0;
    mem_auto = 1'b1; inject = 1'b0; m_ready = 1'b0; m_pend = 1'b0; m_addr = '0;
    exp_last = '0;
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;

    // Reset with requests present: nothing may be accepted, all outputs zero
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 16'h1111; wr_data = 8'h22;
    rd_req = 2'b11; rd_addr = '0;
    pedge(); pedge();
    nedge();
    check("rst_wr_ready", 64'(wr_ready), 64'h0);
    check("rst_rd_gnt", 64'(rd_gnt), 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_wnr", 64'(mem_WnR), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_data", 64'(mem_data), 64'h0);
    check("rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rst_rd_err", 64'(rd_err), 64'h0);
    check("rst_rd_data", 64'(rd_data === '0), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    pedge();
    rst = 1'b0; wr_valid = 1'b0; rd_req = 2'b00;
    cyc();

    // Single write
    wr_valid = 1'b1; wr_addr = 16'h0123; wr_data = 8'hA5;
    nedge();
    check("w1_wr_ready", 64'(wr_ready), 64'h1);
    check("w1_busy_T", 64'(busy), 64'h0);
    pedge();
    wr_valid = 1'b0;
    nedge();
    check("w1_mem_req", 64'(mem_req), 64'h1);
    check("w1_mem_wnr", 64'(mem_WnR), 64'h1);
    check("w1_mem_addr", 64'(mem_addr), 64'h0123);
    check("w1_mem_data", 64'(mem_data), 64'hA5);
    check("w1_busy_T1", 64'(busy), 64'h1);
    pedge();
    nedge();
    check("w1_busy_T2", 64'(busy), 64'h0);
    pedge();

    // Requester 1 reads 0x05F7, nominal latency
    rd_req = 2'b10; rd_addr[AW +: AW] = 16'h05F7;
    nedge();
    check("r1_gnt", 64'(rd_gnt), 64'h2);
    if (rd_gnt === 2'b10) push_rd(2'b10, 1'b0, pat(16'h0500));
    pedge();
    rd_req = 2'b00;
    nedge();
    check("r1_mem_req", 64'(mem_req), 64'h1);
    check("r1_mem_wnr", 64'(mem_WnR), 64'h0);
    check("r1_mem_addr", 64'(mem_addr), 64'h0500);
    pedge();
    cyc();
    nedge();
    check("r1_valid_T3", 64'(rd_valid), 64'h2);
    pedge();
    wait_idle();

    // Write burst limited to 4 while requester 0 waits
    wr_valid = 1'b1; wr_addr = 16'h0200; wr_data = 8'h10;
    rd_req = 2'b01; rd_addr[0 +: AW] = 16'h1234;
    nwr = 0; gcyc = -1; rcyc = -1; nb4 = -1;
    for (int c = 0; c < 40 && nwr < 10; c++) begin
      nedge();
      acc = wr_ready; g = rd_gnt[0];
      if (g) begin
        gcyc = c; nb4 = nwr;
        push_rd(2'b01, 1'b0, pat(16'h1200));
      end
      if (acc) begin
        nwr++;
        if (gcyc >= 0 && rcyc < 0) rcyc = c;
      end
      pedge();
      if (g) rd_req = 2'b00;
      if (acc) begin wr_addr = wr_addr + 16'h1; wr_data = wr_data + 8'h1; end
      if (nwr == 10) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    check("burst_writes_before_gnt", 64'(nb4), 64'd4);
    check("burst_gnt_cycle", 64'(gcyc), 64'd4);
    check("burst_resume_cycle", 64'(rcyc), 64'd7);
    check("burst_total_writes", 64'(nwr), 64'd10);
    wait_idle();

    // Both requesters held: grants alternate starting from requester 1
    rd_addr = {16'hABCD, 16'h1234}; rd_req = 2'b11; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      nedge();
      if (rd_gnt !== 2'b00) begin
        check("alt_gnt", 64'(rd_gnt), 64'(exp_seq[ng]));
        if (exp_seq[ng] == 2'b10) push_rd(2'b10, 1'b0, pat(16'hAB00));
        else                      push_rd(2'b01, 1'b0, pat(16'h1200));
        ng++;
      end
      pedge();
      if (ng == 4) rd_req = 2'b00;
    end
    rd_req = 2'b00;
    check("alt_count", 64'(ng), 64'd4);
    wait_idle();

    // Timeout: memory never answers
    mem_auto = 1'b0;
    rd_req = 2'b01; rd_addr[0 +: AW] = 16'h3456;
    nedge();
    check("to_gnt", 64'(rd_gnt), 64'h1);
    if (rd_gnt === 2'b01) push_rd(2'b01, 1'b1, exp_last);
    pedge();
    rd_req = 2'b00;
    nedge();
    check("to_mem_req", 64'(mem_req), 64'h1);
    pedge();
    k = -1;
    for (int c = 1; c <= 20 && k < 0; c++) begin
      nedge();
      if (rd_valid !== 2'b00) k = c;
      pedge();
    end
    check("to_latency", 64'(k), 64'd9);
    inject = 1'b1;
    nedge();
    pedge();
    inject = 1'b0;
    nedge();
    check("to_late_valid", 64'(rd_valid), 64'h0);
    check("to_rd_data_kept", 64'(rd_data === exp_last), 64'h1);
    pedge();
    mem_auto = 1'b1;
    wait_idle();

    // Reset in the cycle after a read strobe drops the transaction
    rd_req = 2'b10; rd_addr[AW +: AW] = 16'h7777;
    nedge();
    check("rr_gnt", 64'(rd_gnt), 64'h2);
    pedge();
    rd_req = 2'b00;
    nedge();
    check("rr_mem_req", 64'(mem_req), 64'h1);
    pedge();
    rst = 1'b1;
    cyc();
    nedge();
    check("rr_rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rr_rst_mem_req", 64'(mem_req), 64'h0);
    check("rr_rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rr_rst_rd_data", 64'(rd_data === '0), 64'h1);
    check("rr_rst_busy", 64'(busy), 64'h0);
    pedge();
    rst = 1'b0;
    cyc();
    inject = 1'b1;
    nedge();
    check("rr_late_ready_valid", 64'(rd_valid), 64'h0);
    pedge();
    inject = 1'b0;
    cyc();
    nedge();
    check("rr_after_valid", 64'(rd_valid), 64'h0);
    check("rr_after_data", 64'(rd_data === '0), 64'h1);
    pedge();

    // Normal read after the dropped one
    rd_req = 2'b01; rd_addr[0 +: AW] = 16'h9ABC;
    nedge();
    check("rn_gnt", 64'(rd_gnt), 64'h1);
    if (rd_gnt === 2'b01) push_rd(2'b01, 1'b0, pat(16'h9A00));
    pedge();
    rd_req = 2'b00;
    wait_idle();
    check("end_rd_queue_empty", 64'(rq.size()), 64'h0);
    check("end_wr_queue_empty", 64'(wq.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
